ram_stream_out: RTL and testbench

RAM_STREAM_OUT -- requirements
Module: ram_stream_out

---
 rtl/ram_stream_out.sv | 144 ++++++++++++++
 tb/tb_ram_stream_out.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_out.sv
// Streams words 0..len-1 out of RAM_Y onto a valid/ready output port.
// Latency: first read the cycle after start; first out_valid two cycles after that read.
// Backpressure: reads stall once FIFO occupancy plus in-flight reads, net of this cycle's pop, would exceed 2.
module ram_stream_out #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [31:0]           RAM_Y_Do,
    output logic                  RAM_Y_EN,
    output logic [ADDR_WIDTH-1:0] RAM_Y_A,
    output logic [3:0]            RAM_Y_WE,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic [ADDR_WIDTH:0]   xfer_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  inflight_q;
    logic [31:0]           fifo0_q;
    logic [31:0]           fifo1_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;

    logic                  pop;
    logic                  issue;
    logic                  last_xfer;
    logic [2:0]            pending;

    // Read issue: the word popped this cycle frees its slot, so a full-rate
    // stream keeps issuing without bubbles while never exceeding 2 entries.
    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        pending   = {1'b0, count_q} + {2'b00, inflight_q};
        issue     = (state_q == RUN) && (issued_q != len_q) &&
                    (pending < (3'd2 + {2'b00, pop}));
        last_xfer = (state_q == RUN) && pop && (xfer_q == (len_q - CNT_ONE));
    end

    // Control FSM: accepts start in IDLE, counts issued reads and transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            xfer_q   <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            len_q    <= len;
                            addr_q   <= '0;
                            issued_q <= '0;
                            xfer_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        // Natural wrap returns the address to 0 after a full-depth dump.
                        addr_q   <= addr_q + ADDR_ONE;
                        issued_q <= issued_q + CNT_ONE;
                    end
                    if (pop) begin
                        xfer_q <= xfer_q + CNT_ONE;
                    end
                    if (last_xfer) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry output FIFO: captures RAM data the cycle after issue, pops on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= issue;
            if (inflight_q) begin
                if (wr_ptr_q) begin
                    fifo1_q <= RAM_Y_Do;
                end else begin
                    fifo0_q <= RAM_Y_Do;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({inflight_q, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign RAM_Y_EN  = issue;
    assign RAM_Y_A   = addr_q;
    assign RAM_Y_WE  = 4'b0000;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? fifo1_q : fifo0_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_out.sv
// Directed bench for ram_stream_out with a RAM_Y model holding i+0x100 at address i.
module tb_ram_stream_out;

    localparam int AW = 9;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic [31:0]   ram_do;
    logic          RAM_Y_EN;
    logic [AW-1:0] RAM_Y_A;
    logic [3:0]    RAM_Y_WE;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int we_bad  = 0;
    int max_out = 0;
    logic [31:0] xf_q[$];
    int          rd_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;

    ram_stream_out #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .RAM_Y_Do  (ram_do),
        .RAM_Y_EN  (RAM_Y_EN),
        .RAM_Y_A   (RAM_Y_A),
        .RAM_Y_WE  (RAM_Y_WE),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model: RAM_Y[i] = i + 0x100
    always @(posedge clk) begin
        if (RAM_Y_EN) ram_do <= 32'h100 + 32'(RAM_Y_A);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Monitor on the falling edge: log reads and transfers, check hold under stall
    always @(negedge clk) begin
        if (rst_n) begin
            if (RAM_Y_EN) rd_q.push_back(int'(RAM_Y_A));
            if (out_valid && out_ready) xf_q.push_back(out_data);
            if (RAM_Y_WE !== 4'b0000) we_bad++;
            if (prev_stall && out_valid) check("hold_while_stalled", out_data, prev_data);
            if (rd_q.size() - xf_q.size() > max_out) max_out = rd_q.size() - xf_q.size();
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xf_q.delete();
        rd_q.delete();
        max_out = 0;
    endtask

    // Steps until done is seen (leaves the caller in the done cycle)
    task automatic run_until_done(input string tag, input int bound, input logic [3:0] pat,
                                  output int busy_cyc);
        int k;
        busy_cyc = 0;
        for (k = 0; k < bound; k++) begin
            step();
            start     = 1'b0;
            out_ready = pat[k % 4];
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cyc++;
        end
        check({tag, "_done_seen"}, 32'(k < bound), 32'd1);
        check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int n);
        check({tag, "_n_xfers"}, 32'(xf_q.size()), 32'(n));
        check({tag, "_n_reads"}, 32'(rd_q.size()), 32'(n));
        for (int i = 0; i < n && i < xf_q.size(); i++)
            check({tag, "_data"}, xf_q[i], 32'h100 + 32'(i));
        for (int i = 0; i < n && i < rd_q.size(); i++)
            check({tag, "_addr"}, 32'(rd_q[i]), 32'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [7:0] t1_en, t1_val, t1_busy, t1_done;

        rst_n = 1'b0; start = 1'b0; len = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_en",    32'(RAM_Y_EN), 32'd0);
        check("rst_addr",  32'(RAM_Y_A), 32'd0);
        check("rst_we",    32'(RAM_Y_WE), 32'd0);
        check("rst_data",  out_data, 32'd0);
        rst_n = 1'b1;
        step();

        // T1: len=4, out_ready=1, cycle-accurate trace (cycle k = k edges after start)
        t1_en   = 8'b0000_1111;
        t1_val  = 8'b0011_1100;
        t1_busy = 8'b0011_1111;
        t1_done = 8'b0100_0000;
        clear_logs();
        start = 1'b1; len = 10'd4;
        check("t1_c0_en",   32'(RAM_Y_EN), 32'd0);
        check("t1_c0_busy", 32'(busy), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            start = 1'b0;
            check("t1_en",    32'(RAM_Y_EN), 32'(t1_en[k-1]));
            check("t1_valid", 32'(out_valid), 32'(t1_val[k-1]));
            check("t1_busy",  32'(busy), 32'(t1_busy[k-1]));
            check("t1_done",  32'(done), 32'(t1_done[k-1]));
            if (t1_en[k-1])  check("t1_addr", 32'(RAM_Y_A), 32'(k - 1));
            if (t1_val[k-1]) check("t1_data", out_data, 32'h100 + 32'(k - 3));
        end
        check_stream("t1", 4);

        // T2: len=8, out_ready pattern 1,0,0,1 repeating
        clear_logs();
        start = 1'b1; len = 10'd8; out_ready = 1'b1;
        run_until_done("t2", 200, 4'b1001, bc);
        check_stream("t2", 8);
        check("t2_max_outstanding_le2", 32'(max_out <= 2), 32'd1);
        out_ready = 1'b1;

        // T3: full depth, len=512
        step();
        clear_logs();
        start = 1'b1; len = 10'd512;
        run_until_done("t3", 700, 4'b1111, bc);
        check("t3_busy_cycles", 32'(bc), 32'd514);
        check_stream("t3", 512);
        check("t3_addr_wrapped", 32'(RAM_Y_A), 32'd0);
        step();
        check("t3_done_one_cycle", 32'(done), 32'd0);

        // T4: len=0 -> done next cycle, no RAM access, busy stays low
        clear_logs();
        start = 1'b1; len = 10'd0;
        step();
        start = 1'b0;
        check("t4_done",  32'(done), 32'd1);
        check("t4_busy",  32'(busy), 32'd0);
        check("t4_en",    32'(RAM_Y_EN), 32'd0);
        step();
        check("t4_done_pulse_end", 32'(done), 32'd0);
        step();
        check("t4_no_reads", 32'(rd_q.size()), 32'd0);
        check("t4_no_xfers", 32'(xf_q.size()), 32'd0);

        // T5: reset after 3 of 10 words, then a fresh len=2 dump
        clear_logs();
        start = 1'b1; len = 10'd10;
        for (int k = 0; k < 50; k++) begin
            step();
            start = 1'b0;
            if (xf_q.size() >= 3) break;
        end
        check("t5_three_xfers", 32'(xf_q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy), 32'd0);
        check("t5_rst_done",  32'(done), 32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_en",    32'(RAM_Y_EN), 32'd0);
        check("t5_rst_addr",  32'(RAM_Y_A), 32'd0);
        check("t5_rst_we",    32'(RAM_Y_WE), 32'd0);
        check("t5_rst_data",  out_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t5_idle_busy",  32'(busy), 32'd0);
        check("t5_idle_en",    32'(RAM_Y_EN), 32'd0);
        check("t5_idle_valid", 32'(out_valid), 32'd0);
        clear_logs();
        start = 1'b1; len = 10'd2;
        run_until_done("t5b", 50, 4'b1111, bc);
        check_stream("t5b", 2);

        // T6: start while busy is ignored; start in done cycle is accepted
        step();
        clear_logs();
        start = 1'b1; len = 10'd3;
        step();
        start = 1'b0;
        step();
        start = 1'b1; len = 10'd5;
        run_until_done("t6a", 50, 4'b1111, bc);
        check_stream("t6a", 3);
        clear_logs();
        start = 1'b1; len = 10'd2;
        step();
        start = 1'b0;
        check("t6_b2b_busy", 32'(busy), 32'd1);
        check("t6_b2b_en",   32'(RAM_Y_EN), 32'd1);
        run_until_done("t6b", 50, 4'b1111, bc);
        check_stream("t6b", 2);

        check("we_always_zero", 32'(we_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
